// File: rtl/extract_field_sched_pkg.sv
// Shared definitions for the field-extraction scheduler: FSM state encoding
// and default geometry of the header window and offset table.
package extract_field_sched_pkg;

  localparam int DEF_CANDI_NUM     = 128;
  localparam int DEF_OFFSET_WIDTH  = 7;
  localparam int DEF_EXTRACT_WIDTH = 8;
  localparam int DEF_FIELD_NUM     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXTRACT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_OUT     = 2'd3
  } state_e;

endpackage

// File: rtl/extract_field_sched_if.sv
// Header, configuration and result signals of the field-extraction scheduler.
// The requester side uses the master modport, the scheduler the slave modport.
interface extract_field_sched_if
  import extract_field_sched_pkg::*;
#(
  parameter int CANDI_NUM     = DEF_CANDI_NUM,
  parameter int OFFSET_WIDTH  = DEF_OFFSET_WIDTH,
  parameter int EXTRACT_WIDTH = DEF_EXTRACT_WIDTH,
  parameter int FIELD_NUM     = DEF_FIELD_NUM
);
  localparam int FIELD_IDX_W = $clog2(FIELD_NUM);

  logic                                 i_hdr_valid;
  logic                                 o_hdr_ready;
  logic [CANDI_NUM*EXTRACT_WIDTH-1:0]   i_hdr_data;
  logic                                 i_cfg_wren;
  logic [FIELD_IDX_W-1:0]               i_cfg_addr;
  logic [OFFSET_WIDTH-1:0]              i_cfg_offset;
  logic                                 i_cfg_cnt_wren;
  logic [FIELD_IDX_W:0]                 i_cfg_cnt;
  logic                                 o_cfg_err;
  logic [FIELD_NUM*EXTRACT_WIDTH-1:0]   o_fields;
  logic [FIELD_NUM-1:0]                 o_field_mask;
  logic                                 o_valid;
  logic                                 i_ready;

  modport master (
    output i_hdr_valid, i_hdr_data, i_cfg_wren, i_cfg_addr, i_cfg_offset,
           i_cfg_cnt_wren, i_cfg_cnt, i_ready,
    input  o_hdr_ready, o_cfg_err, o_fields, o_field_mask, o_valid
  );

  modport slave (
    input  i_hdr_valid, i_hdr_data, i_cfg_wren, i_cfg_addr, i_cfg_offset,
           i_cfg_cnt_wren, i_cfg_cnt, i_ready,
    output o_hdr_ready, o_cfg_err, o_fields, o_field_mask, o_valid
  );

endinterface

// File: rtl/extract_field_sched_unit.sv
// Registered byte select over the latched header window; one-cycle latency.
// Offsets beyond the window yield zero. The request index travels with the data.
module extract_field_unit #(
  parameter int CANDI_NUM     = 128,
  parameter int OFFSET_WIDTH  = 7,
  parameter int EXTRACT_WIDTH = 8,
  parameter int IDX_W         = 3
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [CANDI_NUM*EXTRACT_WIDTH-1:0] i_window,
  input  logic                               i_req,
  input  logic [IDX_W-1:0]                   i_idx,
  input  logic [OFFSET_WIDTH-1:0]            i_offset,
  output logic                               o_vld,
  output logic [IDX_W-1:0]                   o_idx,
  output logic [EXTRACT_WIDTH-1:0]           o_data
);

  logic [EXTRACT_WIDTH-1:0] sel_s;
  logic [EXTRACT_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     vld_q;

  // Entry mux: no entry matches an out-of-window offset, leaving zero.
  always_comb begin
    sel_s = '0;
    for (int k = 0; k < CANDI_NUM; k++) begin
      if (int'(i_offset) == k) begin
        sel_s = i_window[k*EXTRACT_WIDTH +: EXTRACT_WIDTH];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Output register stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q <= i_req;
      if (i_req) begin
        idx_q  <= i_idx;
        data_q <= sel_s;
      end else begin
        idx_q  <= idx_q;
        data_q <= data_q;
      end
    end
  end

  assign o_vld  = vld_q;
  assign o_idx  = idx_q;
  assign o_data = data_q;

endmodule

// File: rtl/extract_field_sched.sv
// Field-extraction scheduler: latches a header window, walks the offset table
// through one shared extractor and presents the collected fields until consumed.
module extract_field_sched
  import extract_field_sched_pkg::*;
#(
  parameter int CANDI_NUM     = DEF_CANDI_NUM,
  parameter int OFFSET_WIDTH  = DEF_OFFSET_WIDTH,
  parameter int EXTRACT_WIDTH = DEF_EXTRACT_WIDTH,
  parameter int FIELD_NUM     = DEF_FIELD_NUM
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  extract_field_sched_if.slave bus
);

  localparam int FIELD_IDX_W = $clog2(FIELD_NUM);
  localparam int CNT_W       = FIELD_IDX_W + 1;
  localparam int HDR_W       = CANDI_NUM * EXTRACT_WIDTH;
  localparam int FLD_W       = FIELD_NUM * EXTRACT_WIDTH;

  state_e                  state_q, state_d;
  logic [HDR_W-1:0]        hdr_q, hdr_d;
  logic [OFFSET_WIDTH-1:0] tbl_q  [FIELD_NUM];
  logic [OFFSET_WIDTH-1:0] tbl_d  [FIELD_NUM];
  logic [OFFSET_WIDTH-1:0] snap_q [FIELD_NUM];
  logic [OFFSET_WIDTH-1:0] snap_d [FIELD_NUM];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        n_q, n_d;
  logic [FIELD_IDX_W-1:0]  idx_q, idx_d;
  logic [FLD_W-1:0]        fields_q, fields_d;
  logic [FIELD_NUM-1:0]    mask_q, mask_d;
  logic                    valid_q, rdy_q, err_q, err_d;

  logic                     accept_s;
  logic                     unit_req_s;
  logic                     unit_vld_s;
  logic [FIELD_IDX_W-1:0]   unit_idx_s;
  logic [EXTRACT_WIDTH-1:0] unit_data_s;

  // rdy_q mirrors IDLE except on the first cycle out of reset, when it is low.
  assign accept_s   = bus.i_hdr_valid & rdy_q;
  assign unit_req_s = (state_q == ST_EXTRACT);

  // FSM next state, field count snapshot and issue index.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          n_d     = (cnt_q > CNT_W'(FIELD_NUM)) ? CNT_W'(FIELD_NUM) : cnt_q;
          idx_d   = '0;
          state_d = (n_d != '0) ? ST_EXTRACT : ST_OUT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXTRACT: begin
        if ((CNT_W'(idx_q) + CNT_W'(1)) == n_q) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + FIELD_IDX_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT: begin
        if (bus.i_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Header latch, result write-back and configuration table updates.
  always_comb begin
    hdr_d    = hdr_q;
    snap_d   = snap_q;
    tbl_d    = tbl_q;
    cnt_d    = cnt_q;
    fields_d = fields_q;
    mask_d   = mask_q;
    err_d    = 1'b0;
    // The accept snapshots the table so a same-cycle write only affects later headers.
    if (accept_s) begin
      hdr_d    = bus.i_hdr_data;
      snap_d   = tbl_q;
      fields_d = '0;
      mask_d   = '0;
    end else if (unit_vld_s) begin
      for (int i = 0; i < FIELD_NUM; i++) begin
        if (unit_idx_s == FIELD_IDX_W'(i)) begin
          fields_d[i*EXTRACT_WIDTH +: EXTRACT_WIDTH] = unit_data_s;
          mask_d[i]                                  = 1'b1;
        end else begin
          mask_d[i] = mask_d[i];
        end
      end
    end else begin
      mask_d = mask_q;
    end
    if (state_q == ST_IDLE) begin
      for (int i = 0; i < FIELD_NUM; i++) begin
        if (bus.i_cfg_wren && (bus.i_cfg_addr == FIELD_IDX_W'(i))) begin
          tbl_d[i] = bus.i_cfg_offset;
        end else begin
          tbl_d[i] = tbl_q[i];
        end
      end
      if (bus.i_cfg_cnt_wren) begin
        cnt_d = bus.i_cfg_cnt;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      err_d = bus.i_cfg_wren | bus.i_cfg_cnt_wren;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      hdr_q    <= '0;
      tbl_q    <= '{default: '0};
      snap_q   <= '{default: '0};
      cnt_q    <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      fields_q <= '0;
      mask_q   <= '0;
      valid_q  <= 1'b0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      tbl_q    <= tbl_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      fields_q <= fields_d;
      mask_q   <= mask_d;
      valid_q  <= (state_d == ST_OUT);
      rdy_q    <= (state_d == ST_IDLE);
      err_q    <= err_d;
    end
  end

  extract_field_unit #(
    .CANDI_NUM     (CANDI_NUM),
    .OFFSET_WIDTH  (OFFSET_WIDTH),
    .EXTRACT_WIDTH (EXTRACT_WIDTH),
    .IDX_W         (FIELD_IDX_W)
  ) u_unit (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_window (hdr_q),
    .i_req    (unit_req_s),
    .i_idx    (idx_q),
    .i_offset (snap_q[idx_q]),
    .o_vld    (unit_vld_s),
    .o_idx    (unit_idx_s),
    .o_data   (unit_data_s)
  );

  assign bus.o_hdr_ready  = rdy_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_fields     = fields_q;
  assign bus.o_field_mask = mask_q;
  assign bus.o_cfg_err    = err_q;

endmodule

// File: tb/tb_extract_field_sched.sv
// Randomized bench for extract_field_sched against a table-lookup reference model.
// A 100-byte window lets 7-bit offsets fall outside it.
module tb_extract_field_sched;

  localparam int CN  = 100;
  localparam int OW  = 7;
  localparam int EW  = 8;
  localparam int FN  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  extract_field_sched_if #(.CANDI_NUM(CN), .OFFSET_WIDTH(OW), .EXTRACT_WIDTH(EW), .FIELD_NUM(FN)) bus ();

  extract_field_sched #(.CANDI_NUM(CN), .OFFSET_WIDTH(OW), .EXTRACT_WIDTH(EW), .FIELD_NUM(FN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  int          m_tbl [FN];
  int          m_cnt;
  byte unsigned hdr  [CN];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CN*EW-1:0] pack_hdr();
    logic [CN*EW-1:0] v;
    for (int k = 0; k < CN; k++) v[k*EW +: EW] = hdr[k];
    return v;
  endfunction

  // Reference: N = min(count, FN) fields, slot i = header byte at table[i], zero when outside window.
  function automatic void model(output logic [63:0] ef, output logic [7:0] em, output int n);
    ef = '0;
    em = '0;
    n  = (m_cnt > FN) ? FN : m_cnt;
    for (int i = 0; i < n; i++) begin
      ef[i*EW +: EW] = (m_tbl[i] < CN) ? hdr[m_tbl[i]] : 8'd0;
      em[i]          = 1'b1;
    end
  endfunction

  task automatic cfg_tbl(input int a, input int off);
    @(negedge clk);
    bus.i_cfg_wren   = 1'b1;
    bus.i_cfg_addr   = 3'(a);
    bus.i_cfg_offset = 7'(off);
    @(negedge clk);
    bus.i_cfg_wren = 1'b0;
    chk("cfg_err_idle", bus.o_cfg_err, 1'b0);
    m_tbl[a] = off;
  endtask

  task automatic cfg_cnt(input int c);
    @(negedge clk);
    bus.i_cfg_cnt_wren = 1'b1;
    bus.i_cfg_cnt      = 4'(c);
    @(negedge clk);
    bus.i_cfg_cnt_wren = 1'b0;
    chk("cfg_err_idle", bus.o_cfg_err, 1'b0);
    m_cnt = c;
  endtask

  // mode 0: plain; mode 1: config write in the accept cycle; mode 2: table write during EXTRACT (needs N>=3).
  task automatic run_hdr(input int hold, input int mode);
    logic [63:0] ef;
    logic [7:0]  em;
    int n, lat, c, wa, wo, wc;
    model(ef, em, n);
    lat = (n > 0) ? n + 2 : 1;
    @(negedge clk);
    chk("hdr_ready_idle", bus.o_hdr_ready, 1'b1);
    bus.i_hdr_valid = 1'b1;
    bus.i_hdr_data  = pack_hdr();
    wa = $urandom_range(0, FN - 1);
    wo = $urandom_range(0, 127);
    wc = $urandom_range(0, 15);
    if (mode == 1) begin
      bus.i_cfg_wren     = 1'b1;
      bus.i_cfg_addr     = 3'(wa);
      bus.i_cfg_offset   = 7'(wo);
      bus.i_cfg_cnt_wren = 1'b1;
      bus.i_cfg_cnt      = 4'(wc);
    end
    @(negedge clk);
    bus.i_hdr_valid    = 1'b0;
    bus.i_cfg_wren     = 1'b0;
    bus.i_cfg_cnt_wren = 1'b0;
    if (mode == 1) begin
      chk("cfg_err_accept", bus.o_cfg_err, 1'b0);
      m_tbl[wa] = wo;
      m_cnt     = wc;
    end
    if (mode == 2) begin
      bus.i_cfg_wren   = 1'b1;
      bus.i_cfg_addr   = 3'd0;
      bus.i_cfg_offset = 7'(m_tbl[0] + 1);
    end
    c = 1;
    while (bus.o_valid !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
      if (mode == 2 && c == 2) begin
        bus.i_cfg_wren = 1'b0;
        chk("cfg_err_pulse", bus.o_cfg_err, 1'b1);
      end
      if (mode == 2 && c == 3) chk("cfg_err_single", bus.o_cfg_err, 1'b0);
    end
    chk("latency", c, lat);
    chk("fields", bus.o_fields, ef);
    chk("mask", bus.o_field_mask, em);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", bus.o_valid, 1'b1);
      chk("hold_fields", bus.o_fields, ef);
      chk("hold_mask", bus.o_field_mask, em);
      chk("hold_hdr_ready", bus.o_hdr_ready, 1'b0);
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    chk("consume_valid", bus.o_valid, 1'b0);
    chk("consume_hdr_ready", bus.o_hdr_ready, 1'b1);
  endtask

  initial begin
    bus.i_hdr_valid    = 1'b0;
    bus.i_hdr_data     = '0;
    bus.i_cfg_wren     = 1'b0;
    bus.i_cfg_addr     = '0;
    bus.i_cfg_offset   = '0;
    bus.i_cfg_cnt_wren = 1'b0;
    bus.i_cfg_cnt      = '0;
    bus.i_ready        = 1'b0;
    for (int i = 0; i < FN; i++) m_tbl[i] = 0;
    m_cnt = 0;
    #1;
    chk("rst_valid", bus.o_valid, 1'b0);
    chk("rst_hdr_ready", bus.o_hdr_ready, 1'b0);
    chk("rst_fields", bus.o_fields, 64'd0);
    chk("rst_mask", bus.o_field_mask, 8'd0);
    chk("rst_cfg_err", bus.o_cfg_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_hdr_ready", bus.o_hdr_ready, 1'b1);

    // Incrementing header, three fields.
    for (int k = 0; k < CN; k++) hdr[k] = 8'(k);
    cfg_tbl(0, 12);
    cfg_tbl(1, 13);
    cfg_tbl(2, 23);
    cfg_cnt(3);
    run_hdr(2, 0);
    chk("dir_slot2", {56'd0, bus.o_fields[23:16]}, 64'h17);

    // Zero fields, then an over-range count, then a long hold.
    cfg_cnt(0);
    run_hdr(1, 0);
    for (int i = 0; i < FN; i++) cfg_tbl(i, 3 * i + 40);
    cfg_tbl(5, 110);
    cfg_cnt(12);
    run_hdr(0, 0);
    run_hdr(20, 0);

    // Table write while extracting is dropped; the following header still sees the old offset.
    cfg_cnt(3);
    run_hdr(0, 2);
    run_hdr(0, 0);

    // Reset during the second EXTRACT cycle.
    @(negedge clk);
    bus.i_hdr_valid = 1'b1;
    bus.i_hdr_data  = pack_hdr();
    @(negedge clk);
    bus.i_hdr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.o_valid, 1'b0);
    chk("midrst_hdr_ready", bus.o_hdr_ready, 1'b0);
    chk("midrst_mask", bus.o_field_mask, 8'd0);
    for (int i = 0; i < FN; i++) m_tbl[i] = 0;
    m_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      chk("inrst_valid", bus.o_valid, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_hdr_ready", bus.o_hdr_ready, 1'b1);
    chk("postrst_valid", bus.o_valid, 1'b0);
    for (int k = 0; k < CN; k++) hdr[k] = 8'($urandom);
    cfg_cnt(2);
    run_hdr(1, 0);

    // Random headers, tables, counts and hold times.
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < CN; k++) hdr[k] = 8'($urandom);
      repeat ($urandom_range(0, 3)) cfg_tbl($urandom_range(0, FN - 1), $urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) cfg_cnt($urandom_range(0, 15));
      run_hdr($urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
